// File: rtl/fruit_control_if.sv
// Fruit-control bus: game inputs, fruit block feedback, blade position, and the
// control/status outputs produced by the game FSM.
interface fruit_control_if;
    logic       start;
    logic [9:0] fruitX;
    logic [9:0] fruitY;
    logic [9:0] fruitS;
    logic [9:0] bladeX;
    logic [9:0] bladeY;
    logic       blade_down;
    logic       new_fruit;
    logic       move_fruit;
    logic [6:0] fruits_cut;
    logic [2:0] lives;
    logic       cut_flash;
    logic       game_over;

    // FSM side: drives the fruit block controls and game status
    modport master (
        input  start, fruitX, fruitY, fruitS, bladeX, bladeY, blade_down,
        output new_fruit, move_fruit, fruits_cut, lives, cut_flash, game_over
    );

    // Environment side: fruit block, blade input and display overlay
    modport slave (
        output start, fruitX, fruitY, fruitS, bladeX, bladeY, blade_down,
        input  new_fruit, move_fruit, fruits_cut, lives, cut_flash, game_over
    );
endinterface

// File: rtl/fruit_control.sv
// Game-control FSM for the fruit-slicing game. Runs on the frame clock, launches
// fruit, detects slices and misses, and keeps score and lives.
module fruit_control #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned HIT_TOL      = 4,
    parameter int unsigned GRACE_FRAMES = 8,
    parameter int unsigned FLY_TIMEOUT  = 255,
    parameter int unsigned CUT_FRAMES   = 15,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MAX        = 479
) (
    input  logic             frame_clk,
    input  logic             Reset,
    fruit_control_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle, StSpawn, StFly, StCut, StMiss, StGameOver
    } state_e;

    state_e      r_state;
    logic [7:0]  r_fly_cnt;
    logic        r_new_fruit;
    logic        r_move_fruit;
    logic [6:0]  r_fruits_cut;
    logic [2:0]  r_lives;
    logic        r_cut_flash;
    logic        r_game_over;

    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [10:0] w_tol;
    logic        w_hit;
    logic        w_off_screen;
    logic        w_past_grace;

    // Hit window: blade within fruit radius plus tolerance on both axes (11-bit, no wrap)
    always_comb begin
        w_dx  = (bus.bladeX >= bus.fruitX) ? ({1'b0, bus.bladeX} - {1'b0, bus.fruitX})
                                           : ({1'b0, bus.fruitX} - {1'b0, bus.bladeX});
        w_dy  = (bus.bladeY >= bus.fruitY) ? ({1'b0, bus.bladeY} - {1'b0, bus.fruitY})
                                           : ({1'b0, bus.fruitY} - {1'b0, bus.bladeY});
        w_tol = {1'b0, bus.fruitS} + 11'(HIT_TOL);
        w_hit = bus.blade_down && (w_dx <= w_tol) && (w_dy <= w_tol);
        // Wrap above the top edge reads as a large Y and is caught here too
        w_off_screen = (bus.fruitY > 10'(Y_MAX)) || (bus.fruitX > 10'(X_MAX));
        w_past_grace = (r_fly_cnt >= 8'(GRACE_FRAMES));
    end

    // Game FSM with all outputs registered alongside the state
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= StIdle;
            r_fly_cnt    <= 8'd0;
            r_new_fruit  <= 1'b0;
            r_move_fruit <= 1'b0;
            r_fruits_cut <= 7'd0;
            r_lives      <= 3'(LIVES);
            r_cut_flash  <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_new_fruit <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state      <= StSpawn;
                        r_new_fruit  <= 1'b1;
                        r_fruits_cut <= 7'd0;
                        r_lives      <= 3'(LIVES);
                        r_fly_cnt    <= 8'd0;
                    end
                end
                StSpawn: begin
                    r_state      <= StFly;
                    r_move_fruit <= 1'b1;
                    r_fly_cnt    <= 8'd0;
                end
                StFly: begin
                    if (w_hit) begin
                        r_state     <= StCut;
                        r_cut_flash <= 1'b1;
                        r_fly_cnt   <= 8'd0;
                        if (r_fruits_cut != 7'd127) begin
                            r_fruits_cut <= r_fruits_cut + 7'd1;
                        end
                    end else if ((w_past_grace && w_off_screen) ||
                                 (r_fly_cnt == 8'(FLY_TIMEOUT))) begin
                        r_state      <= StMiss;
                        r_move_fruit <= 1'b0;
                        if (r_lives != 3'd0) begin
                            r_lives <= r_lives - 3'd1;
                        end
                    end else if (r_fly_cnt != 8'd255) begin
                        r_fly_cnt <= r_fly_cnt + 8'd1;
                    end
                end
                StCut: begin
                    // Halves keep falling; blade is ignored so a slice counts once
                    if (r_fly_cnt == 8'(CUT_FRAMES - 1)) begin
                        r_state      <= StSpawn;
                        r_new_fruit  <= 1'b1;
                        r_move_fruit <= 1'b0;
                        r_cut_flash  <= 1'b0;
                        r_fly_cnt    <= 8'd0;
                    end else begin
                        r_fly_cnt <= r_fly_cnt + 8'd1;
                    end
                end
                StMiss: begin
                    if (r_lives == 3'd0) begin
                        r_state     <= StGameOver;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state     <= StSpawn;
                        r_new_fruit <= 1'b1;
                        r_fly_cnt   <= 8'd0;
                    end
                end
                StGameOver: begin
                    if (bus.start) begin
                        r_state      <= StSpawn;
                        r_new_fruit  <= 1'b1;
                        r_game_over  <= 1'b0;
                        r_fruits_cut <= 7'd0;
                        r_lives      <= 3'(LIVES);
                        r_fly_cnt    <= 8'd0;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_move_fruit <= 1'b0;
                    r_cut_flash  <= 1'b0;
                    r_game_over  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.new_fruit  = r_new_fruit;
    assign bus.move_fruit = r_move_fruit;
    assign bus.fruits_cut = r_fruits_cut;
    assign bus.lives      = r_lives;
    assign bus.cut_flash  = r_cut_flash;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_fruit_control.sv
// Directed bench for fruit_control: spawn timing, slicing, grace, misses, game over,
// restart, simultaneous hit/off-screen, timeout, score saturation and async reset.
module tb_fruit_control;

    logic frame_clk;
    logic Reset;
    int   n_vec;
    int   n_miss;
    int   exp_score;

    fruit_control_if u_if ();

    fruit_control #(
        .LIVES        (3),
        .HIT_TOL      (4),
        .GRACE_FRAMES (8),
        .FLY_TIMEOUT  (255),
        .CUT_FRAMES   (15),
        .X_MAX        (639),
        .Y_MAX        (479)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (u_if.master)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance n frames, landing 1 time unit after the last rising edge
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    // From SPAWN with fruitY off-screen: enter FLY, survive grace, then miss
    task automatic run_to_miss(input logic [2:0] exp_lives);
        ticks(1);
        chk("miss_fly_move", u_if.move_fruit, 1);
        ticks(8);
        chk("miss_grace_hold", u_if.move_fruit, 1);
        ticks(1);
        chk("miss_move_low", u_if.move_fruit, 0);
        chk("miss_lives", u_if.lives, exp_lives);
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        Reset          = 1'b1;
        u_if.start     = 1'b0;
        u_if.fruitX    = 10'd300;
        u_if.fruitY    = 10'd200;
        u_if.fruitS    = 10'd10;
        u_if.bladeX    = 10'd0;
        u_if.bladeY    = 10'd0;
        u_if.blade_down = 1'b0;
        #2;
        chk("rst_new_fruit", u_if.new_fruit, 0);
        chk("rst_move", u_if.move_fruit, 0);
        chk("rst_score", u_if.fruits_cut, 0);
        chk("rst_lives", u_if.lives, 3);
        chk("rst_flash", u_if.cut_flash, 0);
        chk("rst_game_over", u_if.game_over, 0);
        Reset = 1'b0;

        // IDLE holds without start
        ticks(1);
        chk("idle_hold", u_if.new_fruit, 0);

        // Start: new_fruit on frame 1, motion from frame 2
        u_if.start = 1'b1;
        ticks(1);
        chk("spawn_pulse", u_if.new_fruit, 1);
        chk("spawn_move", u_if.move_fruit, 0);
        u_if.start = 1'b0;
        ticks(1);
        chk("fly_pulse_low", u_if.new_fruit, 0);
        chk("fly_move", u_if.move_fruit, 1);

        // Near miss: dx=15 > 14
        u_if.bladeX = 10'd315;
        u_if.bladeY = 10'd200;
        u_if.blade_down = 1'b1;
        ticks(1);
        chk("nohit_flash", u_if.cut_flash, 0);
        chk("nohit_score", u_if.fruits_cut, 0);

        // Hit at dx=13, dy=14
        u_if.bladeX = 10'd313;
        u_if.bladeY = 10'd186;
        ticks(1);
        chk("hit_flash", u_if.cut_flash, 1);
        chk("hit_score", u_if.fruits_cut, 1);
        chk("hit_move", u_if.move_fruit, 1);
        // Blade stays down over the fruit during CUT: no double count
        for (int i = 0; i < 14; i++) begin
            ticks(1);
            chk("cut_hold_flash", u_if.cut_flash, 1);
            chk("cut_no_recount", u_if.fruits_cut, 1);
        end
        ticks(1);
        chk("cut_respawn", u_if.new_fruit, 1);
        chk("cut_flash_off", u_if.cut_flash, 0);
        u_if.blade_down = 1'b0;

        // Grace: off-screen ignored until fly_cnt reaches 8
        u_if.fruitY = 10'd500;
        ticks(1);
        chk("grace_fly", u_if.move_fruit, 1);
        ticks(4);
        chk("grace_cnt3", u_if.move_fruit, 1);
        ticks(4);
        chk("grace_cnt7", u_if.lives, 3);
        ticks(1);
        chk("grace_miss_move", u_if.move_fruit, 0);
        chk("grace_miss_lives", u_if.lives, 2);
        ticks(1);
        chk("miss_respawn", u_if.new_fruit, 1);

        // Two more misses end the game
        run_to_miss(3'd1);
        ticks(1);
        chk("respawn2", u_if.new_fruit, 1);
        run_to_miss(3'd0);
        ticks(1);
        chk("go_flag", u_if.game_over, 1);
        chk("go_move", u_if.move_fruit, 0);
        chk("go_lives", u_if.lives, 0);
        chk("go_score_hold", u_if.fruits_cut, 1);
        ticks(2);
        chk("go_stays", u_if.game_over, 1);

        // Restart from GAME_OVER
        u_if.fruitY = 10'd200;
        u_if.start = 1'b1;
        ticks(1);
        chk("restart_pulse", u_if.new_fruit, 1);
        chk("restart_lives", u_if.lives, 3);
        chk("restart_score", u_if.fruits_cut, 0);
        chk("restart_go_low", u_if.game_over, 0);
        // start held into FLY is ignored
        ticks(1);
        chk("start_ignored", u_if.new_fruit, 0);
        u_if.start = 1'b0;

        // Hit and off-screen in the same frame after grace: hit wins
        ticks(9);
        chk("pre_both_fly", u_if.move_fruit, 1);
        u_if.fruitX = 10'd700;
        u_if.bladeX = 10'd700;
        u_if.bladeY = 10'd200;
        u_if.blade_down = 1'b1;
        ticks(1);
        chk("both_flash", u_if.cut_flash, 1);
        chk("both_score", u_if.fruits_cut, 1);
        chk("both_lives", u_if.lives, 3);
        u_if.blade_down = 1'b0;
        u_if.fruitX = 10'd300;
        ticks(15);
        chk("both_respawn", u_if.new_fruit, 1);

        // Timeout: on-screen, no hit
        ticks(1);
        ticks(255);
        chk("tmo_still_fly", u_if.move_fruit, 1);
        chk("tmo_lives_pre", u_if.lives, 3);
        ticks(1);
        chk("tmo_miss_move", u_if.move_fruit, 0);
        chk("tmo_miss_lives", u_if.lives, 2);
        ticks(1);
        chk("tmo_respawn", u_if.new_fruit, 1);

        // Score saturation over 130 hits
        u_if.bladeX = 10'd300;
        u_if.bladeY = 10'd200;
        u_if.blade_down = 1'b1;
        exp_score = 1;
        for (int i = 0; i < 130; i++) begin
            ticks(2);
            exp_score = (exp_score < 127) ? exp_score + 1 : 127;
            chk("sat_score", u_if.fruits_cut, exp_score);
            ticks(15);
        end
        chk("sat_final", u_if.fruits_cut, 127);
        u_if.blade_down = 1'b0;

        // Asynchronous reset mid-FLY
        ticks(1);
        chk("pre_rst_move", u_if.move_fruit, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_new_fruit", u_if.new_fruit, 0);
        chk("arst_move", u_if.move_fruit, 0);
        chk("arst_score", u_if.fruits_cut, 0);
        chk("arst_lives", u_if.lives, 3);
        chk("arst_game_over", u_if.game_over, 0);
        chk("arst_flash", u_if.cut_flash, 0);
        Reset = 1'b0;
        ticks(1);
        chk("post_rst_idle", u_if.new_fruit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fruit_control.md
Name: fruit_control

Overview:
- Game-control FSM on frame_clk that drives the fruit motion block's control inputs (new_fruit, move_fruit, fruits cut count).
- Consumes the fruit block's fruitX/fruitY/fruitS outputs and the blade (mouse) position.
- Decides per frame whether the fruit was sliced, missed (left screen) or still flying.
- Tracks score and lives, and signals game over to the display/overlay logic.

Parameters:
- LIVES, 3, misses allowed before game over (1..7)
- HIT_TOL, 4, extra pixels added to fruitS for the hit window
- GRACE_FRAMES, 8, frames after spawn during which off-screen is not checked
- FLY_TIMEOUT, 255, max frames in flight before a forced miss
- CUT_FRAMES, 15, frames the cut/split state is held before respawn
- X_MAX, 639, rightmost visible X
- Y_MAX, 479, bottommost visible Y

Ports:
- frame_clk  in  1  frame clock, one edge per video frame
- Reset  in  1  asynchronous, active-high reset
- start  in  1  level; starts a game from IDLE or GAME_OVER
- fruitX  in  10  fruit centre X from the fruit block
- fruitY  in  10  fruit centre Y from the fruit block
- fruitS  in  10  fruit radius from the fruit block
- bladeX  in  10  blade/cursor X
- bladeY  in  10  blade/cursor Y
- blade_down  in  1  blade active (mouse button held)
- new_fruit  out  1  one-frame pulse: fruit block loads a new launch
- move_fruit  out  1  fruit block integrates motion
- fruits_cut  out  7  score, saturating at 127
- lives  out  3  remaining lives
- cut_flash  out  1  high while in CUT (split sprite / flash)
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async, any state) -> IDLE; new_fruit=0, move_fruit=0, fruits_cut=0, lives=LIVES, cut_flash=0, game_over=0; frame counter fly_cnt=0.
- All outputs are registered; state changes on the rising edge of frame_clk only.
- IDLE: all pulses low. When start=1 -> SPAWN; fruits_cut<=0, lives<=LIVES.
- SPAWN: new_fruit=1 for exactly one frame; move_fruit=0; fly_cnt<=0. Next frame -> FLY.
- FLY: move_fruit=1 and fly_cnt increments each frame, saturating at 255. Evaluated in priority order each frame:
  1. hit -> CUT; fruits_cut increments, saturating at 127.
  2. Else if fly_cnt>=GRACE_FRAMES and (fruitY>Y_MAX or fruitX>X_MAX) -> MISS. This also covers 10-bit wrap above the screen top, which reads as a large value.
  3. Else if fly_cnt==FLY_TIMEOUT -> MISS.
  4. Else stay in FLY.
- Hit definition (combinational on current inputs, 11-bit arithmetic, no overflow): blade_down=1 and |bladeX-fruitX| <= fruitS+HIT_TOL and |bladeY-fruitY| <= fruitS+HIT_TOL. Hit during grace frames is allowed.
- Simultaneous hit and off-screen in the same frame: hit wins.
- CUT: cut_flash=1, move_fruit=1 so the halves keep falling, fly_cnt reused as hold counter (cleared on entry). After CUT_FRAMES frames -> SPAWN. blade_down has no effect in CUT (no double count).
- MISS: one frame; move_fruit=0. lives decrements.
  - If lives was 1 (becomes 0) -> GAME_OVER.
  - Otherwise -> SPAWN.
- GAME_OVER: game_over=1, move_fruit=0; fruits_cut and lives hold. start=1 -> SPAWN with fruits_cut<=0 and lives<=LIVES (same as IDLE exit).
- start is ignored outside IDLE and GAME_OVER.
- fruits_cut drives the fruit block's speed-scaling input directly.

Test Plan:
- Reset high mid-FLY -> on the same cycle: state IDLE, new_fruit=0, move_fruit=0, fruits_cut=0, lives=3, game_over=0.
- start=1 in IDLE -> new_fruit=1 exactly on frame 1, move_fruit=1 from frame 2 onward, new_fruit=0 after.
- FLY with fruit=(300,200), fruitS=10, blade=(313,186), blade_down=1:
  - Expected: |13|,|14| <= 14 -> CUT next frame, fruits_cut 0->1, cut_flash high for 15 frames, then new_fruit pulse.
  - Same with blade=(315,200): no hit.
- fruitY=500 at fly_cnt=3: no miss (grace). At fly_cnt=8: MISS, lives 3->2, then SPAWN.
- Three consecutive misses -> lives 0, game_over=1, move_fruit=0; then start=1 -> new_fruit pulse, lives=3, fruits_cut=0.
- Same frame hit and fruitX=700 after grace -> CUT, score +1, lives unchanged.
- Force 130 hits -> fruits_cut saturates at 127.
- Hold in FLY 255 frames on-screen with no hit -> MISS via FLY_TIMEOUT.
